// File: rtl/clk_enable_gen.sv
`default_nettype none
// ============================================================================
//  Module      : clk_enable_gen
//  Description : Programmable clock-enable generator. Emits a one-cycle tick
//                every (DIV+1) clk cycles plus a square wave that toggles on
//                each tick. Supports periodic and one-shot modes, runtime
//                divisor reload, pause, and counter readback.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_enable_gen #(
    parameter int               WIDTH       = 24,
    parameter logic [WIDTH-1:0] DEFAULT_DIV = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] div_i,
    input  logic             mode_i,
    output logic             tick_o,
    output logic             sq_o,
    output logic             busy_o,
    output logic [WIDTH-1:0] cnt_o
);

    localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_div;
    logic             r_mode;
    logic             r_run;
    logic             r_tick;
    logic             r_sq;
    logic             w_terminal;

    // Counter has reached the programmed divisor; the next enabled edge wraps it.
    assign w_terminal = (r_cnt == r_div);

    // Counter, divisor/mode capture, tick and square-wave generation.
    // A load beats counting; counting only advances while enabled and armed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_div  <= DEFAULT_DIV;
            r_mode <= 1'b0;
            r_run  <= 1'b1;
            r_tick <= 1'b0;
            r_sq   <= 1'b0;
        end else if (load_i) begin
            // Reload discards the running count; square wave phase is kept.
            r_div  <= div_i;
            r_mode <= mode_i;
            r_cnt  <= '0;
            r_run  <= 1'b1;
            r_tick <= 1'b0;
        end else if (en_i && r_run) begin
            if (w_terminal) begin
                // Wrap via the terminal path so the counter never overflows.
                r_cnt  <= '0;
                r_tick <= 1'b1;
                r_sq   <= ~r_sq;
                if (r_mode) begin
                    r_run <= 1'b0;
                end
            end else begin
                r_cnt  <= r_cnt + c_ONE;
                r_tick <= 1'b0;
            end
        end else begin
            // Paused or disarmed: hold state, never repeat a tick.
            r_tick <= 1'b0;
        end
    end

    assign tick_o = r_tick;
    assign sq_o   = r_sq;
    assign busy_o = r_run;
    assign cnt_o  = r_cnt;

endmodule
`default_nettype wire
